seven_seg: RTL and testbench

Registered hexadecimal-to-seven-segment decoder driving one board display digit. Each instance converts a 4-bit nibble (0x0–0xF) into a 7-bit segment pattern, with blanking and lamp-test overrides. Four instances sit beside the memory stage's memory-mapped HEX register (address 0x3FE), one per nibble of the 16-bit display value, and drive O_HEX3..O_HEX0.

---
 rtl/seven_seg.sv | 56 +++++
 tb/tb_seven_seg.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg.sv
// seven_seg: registered hex nibble to seven-segment decoder
// with blank and lamp-test overrides; bit0=a .. bit6=g.
module seven_seg #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       I_CLOCK,
  input  logic       I_RESET,
  input  logic [3:0] IN,
  input  logic       I_BLANK,
  input  logic       I_LAMPTEST,
  output logic [6:0] OUT
);

  // Lit patterns in active-low form, g in the MSB.
  localparam logic [6:0] LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0] ALL_ON  = 7'h00;
  localparam logic [6:0] ALL_OFF = 7'h7F;
  localparam logic [6:0] DARK    =
    ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [6:0] lit;
  logic [6:0] out_d;
  logic [6:0] out_q;

  // Pick lamp test, blank or decode, then apply polarity.
  always_comb begin
    lit   = LUT[IN];
    out_d = lit;
    if (I_LAMPTEST) begin
      out_d = ALL_ON;
    end else if (I_BLANK) begin
      out_d = ALL_OFF;
    end
    if (!ACTIVE_LOW) begin
      out_d = ~out_d;
    end
  end

  // Output register; reset shows a dark digit immediately.
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      out_q <= DARK;
    end else begin
      out_q <= out_d;
    end
  end

  assign OUT = out_q;

endmodule

// File: tb/tb_seven_seg.sv
// tb_seven_seg: vector table plus scoreboard queue
// against the seven_seg decoder.
module tb_seven_seg;

  logic        clk;
  logic        rst;
  logic [3:0]  in_v;
  logic        blank;
  logic        lamp;
  logic [15:0] hex_val;
  logic [6:0]  out_l;
  logic [6:0]  out_h;
  logic [6:0]  hex3, hex2, hex1, hex0;

  int tests;
  int fails;

  typedef struct {
    logic [3:0] in;
    logic       blank;
    logic       lamp;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs [$];
  logic [6:0] sb [$];

  seven_seg #(.ACTIVE_LOW(1'b1)) dut (
    .I_CLOCK(clk), .I_RESET(rst), .IN(in_v),
    .I_BLANK(blank), .I_LAMPTEST(lamp), .OUT(out_l)
  );

  seven_seg #(.ACTIVE_LOW(1'b0)) dut_h (
    .I_CLOCK(clk), .I_RESET(rst), .IN(in_v),
    .I_BLANK(blank), .I_LAMPTEST(lamp), .OUT(out_h)
  );

  seven_seg u_hex3 (
    .I_CLOCK(clk), .I_RESET(rst), .IN(hex_val[15:12]),
    .I_BLANK(1'b0), .I_LAMPTEST(1'b0), .OUT(hex3)
  );
  seven_seg u_hex2 (
    .I_CLOCK(clk), .I_RESET(rst), .IN(hex_val[11:8]),
    .I_BLANK(1'b0), .I_LAMPTEST(1'b0), .OUT(hex2)
  );
  seven_seg u_hex1 (
    .I_CLOCK(clk), .I_RESET(rst), .IN(hex_val[7:4]),
    .I_BLANK(1'b0), .I_LAMPTEST(1'b0), .OUT(hex1)
  );
  seven_seg u_hex0 (
    .I_CLOCK(clk), .I_RESET(rst), .IN(hex_val[3:0]),
    .I_BLANK(1'b0), .I_LAMPTEST(1'b0), .OUT(hex0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [6:0] act,
                     input logic [6:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one vector at the falling edge, check the lag,
  // then pop and compare after the next rising edge.
  task automatic step(input vec_t v, input logic [6:0] prev);
    logic [6:0] e;
    @(negedge clk);
    in_v  = v.in;
    blank = v.blank;
    lamp  = v.lamp;
    sb.push_back(v.exp);
    #1;
    chk("lag_low", out_l, prev);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("out_low", out_l, e);
    chk("out_high", out_h, ~e);
  endtask

  initial begin
    logic [6:0] prev;
    tests   = 0;
    fails   = 0;
    rst     = 1'b1;
    in_v    = 4'h8;
    blank   = 1'b0;
    lamp    = 1'b1;
    hex_val = 16'h0000;

    #2;
    chk("rst_low", out_l, 7'h7F);
    chk("rst_high", out_h, 7'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold_low", out_l, 7'h7F);
      chk("rst_hold_high", out_h, 7'h00);
    end
    @(negedge clk);
    rst  = 1'b0;
    lamp = 1'b0;
    @(posedge clk);
    #1;
    chk("release", out_l, 7'h00);

    vecs.push_back('{4'h0, 1'b0, 1'b0, 7'h40});
    vecs.push_back('{4'h1, 1'b0, 1'b0, 7'h79});
    vecs.push_back('{4'h2, 1'b0, 1'b0, 7'h24});
    vecs.push_back('{4'h3, 1'b0, 1'b0, 7'h30});
    vecs.push_back('{4'h4, 1'b0, 1'b0, 7'h19});
    vecs.push_back('{4'h5, 1'b0, 1'b0, 7'h12});
    vecs.push_back('{4'h6, 1'b0, 1'b0, 7'h02});
    vecs.push_back('{4'h7, 1'b0, 1'b0, 7'h78});
    vecs.push_back('{4'h8, 1'b0, 1'b0, 7'h00});
    vecs.push_back('{4'h9, 1'b0, 1'b0, 7'h10});
    vecs.push_back('{4'hA, 1'b0, 1'b0, 7'h08});
    vecs.push_back('{4'hB, 1'b0, 1'b0, 7'h03});
    vecs.push_back('{4'hC, 1'b0, 1'b0, 7'h46});
    vecs.push_back('{4'hD, 1'b0, 1'b0, 7'h21});
    vecs.push_back('{4'hE, 1'b0, 1'b0, 7'h06});
    vecs.push_back('{4'hF, 1'b0, 1'b0, 7'h0E});
    vecs.push_back('{4'h3, 1'b1, 1'b0, 7'h7F});
    vecs.push_back('{4'h3, 1'b1, 1'b1, 7'h00});
    vecs.push_back('{4'h3, 1'b0, 1'b0, 7'h30});
    vecs.push_back('{4'h3, 1'b0, 1'b1, 7'h00});
    vecs.push_back('{4'h0, 1'b0, 1'b0, 7'h40});

    prev = 7'h00;
    foreach (vecs[i]) begin
      step(vecs[i], prev);
      prev = vecs[i].exp;
    end

    @(negedge clk);
    hex_val = 16'hBEEF;
    @(posedge clk);
    #1;
    chk("hex3", hex3, 7'h03);
    chk("hex2", hex2, 7'h06);
    chk("hex1", hex1, 7'h06);
    chk("hex0", hex0, 7'h0E);

    @(posedge clk);
    #1;
    in_v = 4'h5;
    #4;
    rst = 1'b1;
    #1;
    chk("async_low", out_l, 7'h7F);
    chk("async_high", out_h, 7'h00);
    @(posedge clk);
    #1;
    chk("async_hold", out_l, 7'h7F);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("no_early_5", out_l, 7'h7F);
    @(posedge clk);
    #1;
    chk("after_rel", out_l, 7'h12);
    chk("after_rel_h", out_h, 7'h6D);

    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL sb_drain: got %0d left expected 0",
               sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
